// File: rtl/mod_enc_roundctrl.sv
// AES-256 encryption round sequencer: walks key fetch, addRoundKey, subBytes, shiftRows, mixColumns.
// Optional watchdog on every wait state is enabled by defining ENC_ROUNDCTRL_TIMEOUT_EN.
module mod_enc_roundctrl #(
    parameter int NR = 14
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [3:0] round,
    output logic       key_rd,
    output logic [3:0] key_addr,
    input  logic       key_valid,
    output logic       ark_start,
    output logic       sb_start,
    output logic       sr_start,
    output logic       mc_start,
    input  logic       ark_ok,
    input  logic       sb_ok,
    input  logic       sr_ok,
    input  logic       mc_ok,
    output logic [1:0] ark_sel,
    output logic       err
);

    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WKEY, S_ARK, S_WARK, S_SB,
        S_WSB, S_SR, S_WSR, S_MC, S_WMC, S_DONE
    } state_t;

    state_t state;
    logic   wait_st;
    logic   hs;
    logic   timeout;

    function automatic logic [1:0] sel_for(input logic [3:0] r);
        if (r == 4'd0)
            return 2'b00;
        else if (r == LAST)
            return 2'b10;
        else
            return 2'b01;
    endfunction

    // Only the handshake belonging to the current wait state is visible.
    always_comb begin
        wait_st = 1'b0;
        hs      = 1'b0;
        case (state)
            S_WKEY: begin wait_st = 1'b1; hs = key_valid; end
            S_WARK: begin wait_st = 1'b1; hs = ark_ok;    end
            S_WSB:  begin wait_st = 1'b1; hs = sb_ok;     end
            S_WSR:  begin wait_st = 1'b1; hs = sr_ok;     end
            S_WMC:  begin wait_st = 1'b1; hs = mc_ok;     end
            default: ;
        endcase
    end

`ifdef ENC_ROUNDCTRL_TIMEOUT_EN
    logic [15:0] wdog;

    // Non-wait states last one cycle, so clearing outside wait states covers every state change.
    always_ff @(posedge clk) begin
        if (resetn || !wait_st)
            wdog <= 16'd0;
        else
            wdog <= wdog + 16'd1;
    end

    assign timeout = (wdog == 16'hFFFF);

    always_ff @(posedge clk) begin
        if (resetn)
            err <= 1'b0;
        else if (wait_st && !hs && timeout)
            err <= 1'b1;
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (resetn) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            round     <= 4'd0;
            key_rd    <= 1'b0;
            key_addr  <= 4'd0;
            ark_start <= 1'b0;
            sb_start  <= 1'b0;
            sr_start  <= 1'b0;
            mc_start  <= 1'b0;
            ark_sel   <= 2'b00;
        end else begin
            key_rd    <= 1'b0;
            ark_start <= 1'b0;
            sb_start  <= 1'b0;
            sr_start  <= 1'b0;
            mc_start  <= 1'b0;
            done      <= 1'b0;
            if (wait_st && !hs && timeout) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        state    <= S_FETCH;
                        busy     <= 1'b1;
                        round    <= 4'd0;
                        key_rd   <= 1'b1;
                        key_addr <= 4'd0;
                    end
                    S_FETCH: state <= S_WKEY;
                    S_WKEY: if (hs) begin
                        state     <= S_ARK;
                        ark_start <= 1'b1;
                        ark_sel   <= sel_for(round);
                    end
                    S_ARK: state <= S_WARK;
                    S_WARK: if (hs) begin
                        if (round == LAST) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            round    <= round + 4'd1;
                            state    <= S_SB;
                            sb_start <= 1'b1;
                        end
                    end
                    S_SB: state <= S_WSB;
                    S_WSB: if (hs) begin
                        state    <= S_SR;
                        sr_start <= 1'b1;
                    end
                    S_SR: state <= S_WSR;
                    // The final round has no mixColumns step.
                    S_WSR: if (hs) begin
                        if (round == LAST) begin
                            state    <= S_FETCH;
                            key_rd   <= 1'b1;
                            key_addr <= round;
                        end else begin
                            state    <= S_MC;
                            mc_start <= 1'b1;
                        end
                    end
                    S_MC: state <= S_WMC;
                    S_WMC: if (hs) begin
                        state    <= S_FETCH;
                        key_rd   <= 1'b1;
                        key_addr <= round;
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mod_enc_roundctrl.sv
// Scoreboard bench for mod_enc_roundctrl: queued expected pulse sequence checked by a monitor.
module tb_mod_enc_roundctrl;

    localparam int NR = 14;
    localparam logic [3:0] K_KEY  = 4'd1;
    localparam logic [3:0] K_ARK  = 4'd2;
    localparam logic [3:0] K_SB   = 4'd3;
    localparam logic [3:0] K_SR   = 4'd4;
    localparam logic [3:0] K_MC   = 4'd5;
    localparam logic [3:0] K_DONE = 4'd6;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, key_rd;
    logic [3:0] round, key_addr;
    logic       key_valid = 1'b0;
    logic       ark_start, sb_start, sr_start, mc_start;
    logic       ark_ok = 1'b0, sb_ok_r = 1'b0, sr_ok = 1'b0, mc_ok = 1'b0;
    logic       sb_spur = 1'b0;
    logic       sb_ok_w;
    logic [1:0] ark_sel;
    logic       err;

    assign sb_ok_w = sb_ok_r | sb_spur;

    mod_enc_roundctrl #(.NR(NR)) dut (
        .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done),
        .round(round), .key_rd(key_rd), .key_addr(key_addr), .key_valid(key_valid),
        .ark_start(ark_start), .sb_start(sb_start), .sr_start(sr_start), .mc_start(mc_start),
        .ark_ok(ark_ok), .sb_ok(sb_ok_w), .sr_ok(sr_ok), .mc_ok(mc_ok),
        .ark_sel(ark_sel), .err(err)
    );

    initial forever #5 clk = ~clk;

    logic [11:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    bit slow = 1'b0;
    bit hold = 1'b0;
    bit spur = 1'b0;

    function automatic logic [11:0] mk(input logic [3:0] k, input logic [3:0] a, input logic [1:0] s);
        return {2'b00, k, a, s};
    endfunction

    task automatic check(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, want);
        end
    endtask

    // Expected pulse order up to and including the addRoundKey of round 'upto'.
    task automatic push_seq(input int upto);
        exp_q.push_back(mk(K_KEY, 4'd0, 2'b00));
        exp_q.push_back(mk(K_ARK, 4'd0, 2'b00));
        for (int r = 1; r <= upto; r++) begin
            exp_q.push_back(mk(K_SB, 4'(r), 2'b00));
            exp_q.push_back(mk(K_SR, 4'(r), 2'b00));
            if (r < NR) exp_q.push_back(mk(K_MC, 4'(r), 2'b00));
            exp_q.push_back(mk(K_KEY, 4'(r), 2'b00));
            exp_q.push_back(mk(K_ARK, 4'(r), (r == NR) ? 2'b10 : 2'b01));
        end
        if (upto == NR) exp_q.push_back(mk(K_DONE, 4'(NR), 2'b00));
    endtask

    task automatic got_ev(input logic [11:0] ev);
        logic [11:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event got=%0d expected=none", ev);
        end else begin
            e = exp_q.pop_front();
            check("event", int'(ev), int'(e));
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (key_rd)    got_ev(mk(K_KEY, key_addr, 2'b00));
            if (ark_start) got_ev(mk(K_ARK, round, ark_sel));
            if (sb_start)  got_ev(mk(K_SB, round, 2'b00));
            if (sr_start)  got_ev(mk(K_SR, round, 2'b00));
            if (mc_start)  got_ev(mk(K_MC, round, 2'b00));
            if (done) begin
                got_ev(mk(K_DONE, round, 2'b00));
                done_cnt++;
                done_cyc = cyc;
            end
        end
    endtask

    task automatic ticker();
        forever begin
            @(posedge clk);
            cyc++;
        end
    endtask

    function automatic logic req_of(input int id);
        case (id)
            0: return key_rd;
            1: return ark_start;
            2: return sb_start;
            3: return sr_start;
            default: return mc_start;
        endcase
    endfunction

    function automatic int lat_of(input int id);
        case (id)
            0: return (slow && key_addr == 4'd7) ? 3 : 1;
            1: return (hold && round == 4'd5) ? 0 : 1;
            4: return (slow && round == 4'd7) ? 5 : 1;
            default: return 1;
        endcase
    endfunction

    task automatic drive(input int id, input logic v);
        case (id)
            0: key_valid = v;
            1: ark_ok = v;
            2: sb_ok_r = v;
            3: sr_ok = v;
            default: mc_ok = v;
        endcase
    endtask

    task automatic responder(input int id);
        int lat;
        bit sp;
        forever begin
            @(negedge clk);
            if (req_of(id)) begin
                lat = lat_of(id);
                sp = (id == 1) && spur && (round == 4'd3);
                if (lat > 0) begin
                    repeat (lat) @(posedge clk);
                    #1 drive(id, 1'b1);
                    if (sp) sb_spur = 1'b1;
                    @(posedge clk);
                    #1 drive(id, 1'b0);
                    if (sp) sb_spur = 1'b0;
                end
            end
        end
    endtask

    task automatic kick(output int c0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 c0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, input int d0, input int want, input string nm);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == d0)
            check({nm, "_done_timeout"}, 0, 1);
        else
            check({nm, "_latency"}, done_cyc - c0, want);
        repeat (4) @(posedge clk);
        #1;
        check({nm, "_queue_left"}, exp_q.size(), 0);
        check({nm, "_busy_after"}, int'(busy), 0);
        check({nm, "_done_count"}, done_cnt - d0, 1);
        check({nm, "_err"}, int'(err), 0);
    endtask

    initial begin
        int c0;
        int d0;
        int n;
        bit seen;

        fork
            monitor();
            ticker();
            responder(0);
            responder(1);
            responder(2);
            responder(3);
            responder(4);
        join_none

        // Reset held for two cycles, then idle.
        repeat (2) @(posedge clk);
        #1 resetn = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_round", int'(round), 0);
        check("rst_key_addr", int'(key_addr), 0);
        check("rst_ark_sel", int'(ark_sel), 0);
        check("rst_pulses", int'({done, key_rd, ark_start, sb_start, sr_start, mc_start}), 0);
        check("rst_err", int'(err), 0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        check("idle_busy", int'(seen), 0);

        // Zero-wait baseline.
        push_seq(NR);
        d0 = done_cnt;
        kick(c0);
        wait_done(c0, d0, 142, "baseline");

        // Slow mixColumns and key ROM in round 7.
        slow = 1'b1;
        push_seq(NR);
        d0 = done_cnt;
        kick(c0);
        wait_done(c0, d0, 148, "latency");
        slow = 1'b0;

        // Spurious sb_ok during WARK of round 3 and a start pulse while busy.
        spur = 1'b1;
        push_seq(NR);
        d0 = done_cnt;
        kick(c0);
        repeat (50) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(c0, d0, 142, "spurious");
        spur = 1'b0;

        // Reset during WMC of round 9.
        push_seq(NR);
        d0 = done_cnt;
        kick(c0);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 2000) begin
            @(negedge clk);
            n++;
            if (mc_start && round == 4'd9) seen = 1'b1;
        end
        check("midrst_reach", int'(seen), 1);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_round", int'(round), 0);
        check("midrst_pulses", int'({done, key_rd, ark_start, sb_start, sr_start, mc_start}), 0);
        resetn = 1'b0;
        exp_q.delete();
        repeat (5) @(posedge clk);
        #1;
        check("midrst_idle_busy", int'(busy), 0);
        check("midrst_no_done", done_cnt - d0, 0);
        push_seq(NR);
        d0 = done_cnt;
        kick(c0);
        wait_done(c0, d0, 142, "after_rst");

`ifdef ENC_ROUNDCTRL_TIMEOUT_EN
        // Withhold ark_ok in round 5 until the watchdog fires.
        hold = 1'b1;
        push_seq(5);
        d0 = done_cnt;
        kick(c0);
        n = 0;
        while (!err && n < 70000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("wdog_err", int'(err), 1);
        check("wdog_busy", int'(busy), 0);
        repeat (10) @(posedge clk);
        #1;
        check("wdog_err_sticky", int'(err), 1);
        check("wdog_no_done", done_cnt - d0, 0);
        check("wdog_queue_left", exp_q.size(), 0);
        hold = 1'b0;
        resetn = 1'b1;
        @(posedge clk);
        #1 resetn = 1'b0;
        check("wdog_err_cleared", int'(err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
